// File: rtl/enigma_pkg.sv
// Shared constants, FSM encoding and position arithmetic for the Enigma rotor stepper.
package enigma_pkg;
    localparam int POS_W = 5;
    localparam logic [POS_W-1:0] ALPHA      = 5'd26;
    localparam logic [POS_W-1:0] LAST_POS   = 5'd25;
    localparam logic [POS_W-1:0] DEF_NOTCH1 = 5'd16;
    localparam logic [POS_W-1:0] DEF_NOTCH2 = 5'd4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STEP    = 2'd1,
        S_ENCRYPT = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    function automatic logic [POS_W-1:0] wrap_inc(input logic [POS_W-1:0] p);
        return (p >= LAST_POS) ? '0 : p + 5'd1;
    endfunction
endpackage

// File: rtl/rotor_counter.sv
// One rotor position: modulo-26 register with load (out-of-range loads become 0),
// step, and a flag raised while the position sits on this rotor's notch.
module rotor_counter
    import enigma_pkg::*;
#(
    parameter logic [POS_W-1:0] NOTCH = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [POS_W-1:0] load_val_i,
    input  logic             step_i,
    output logic [POS_W-1:0] pos_o,
    output logic             at_notch_o
);
    logic [POS_W-1:0] pos_q, pos_d;

    always_comb begin
        pos_d = pos_q;
        if (load_i)
            pos_d = (load_val_i < ALPHA) ? load_val_i : '0;
        else if (step_i)
            pos_d = wrap_inc(pos_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) pos_q <= '0;
        else        pos_q <= pos_d;
    end

    assign pos_o      = pos_q;
    assign at_notch_o = (pos_q == NOTCH);
endmodule

// File: rtl/enigma_stepper.sv
// Three-rotor Enigma stepping controller: accepts a key, steps the rotors (with the
// double-step anomaly), samples the external encryption path and holds the result.
module enigma_stepper
    import enigma_pkg::*;
#(
    parameter logic [POS_W-1:0] NOTCH1 = DEF_NOTCH1,
    parameter logic [POS_W-1:0] NOTCH2 = DEF_NOTCH2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic [POS_W-1:0] load_r1,
    input  logic [POS_W-1:0] load_r2,
    input  logic [POS_W-1:0] load_r3,
    input  logic             key_valid,
    input  logic [POS_W-1:0] key_code,
    output logic             key_ready,
    output logic [POS_W-1:0] r1,
    output logic [POS_W-1:0] r2,
    output logic [POS_W-1:0] r3,
    output logic [POS_W-1:0] enc_in,
    input  logic [POS_W-1:0] enc_out,
    output logic             out_valid,
    output logic [POS_W-1:0] out_code,
    input  logic             out_ready,
    output logic             bad_key
);
    state_e           state_q;
    logic [POS_W-1:0] key_q;
    logic [POS_W-1:0] out_code_q;
    logic             out_valid_q;
    logic             bad_key_q;

    logic load_go, key_fire, stepping;
    logic r1_notch, r2_notch, r3_notch_unused;

    assign key_ready = rst_n && (state_q == S_IDLE) && !load_en;
    assign key_fire  = key_ready && key_valid;
    assign load_go   = (state_q == S_IDLE) && load_en;
    assign stepping  = (state_q == S_STEP);

    // Notch flags reflect the pre-step positions, so r2 double-steps off its own notch.
    rotor_counter #(.NOTCH(NOTCH1)) u_r1 (
        .clk(clk), .rst_n(rst_n), .load_i(load_go), .load_val_i(load_r1),
        .step_i(stepping), .pos_o(r1), .at_notch_o(r1_notch)
    );
    rotor_counter #(.NOTCH(NOTCH2)) u_r2 (
        .clk(clk), .rst_n(rst_n), .load_i(load_go), .load_val_i(load_r2),
        .step_i(stepping && (r1_notch || r2_notch)), .pos_o(r2), .at_notch_o(r2_notch)
    );
    rotor_counter #(.NOTCH('0)) u_r3 (
        .clk(clk), .rst_n(rst_n), .load_i(load_go), .load_val_i(load_r3),
        .step_i(stepping && r2_notch), .pos_o(r3), .at_notch_o(r3_notch_unused)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            key_q       <= '0;
            out_code_q  <= '0;
            out_valid_q <= 1'b0;
            bad_key_q   <= 1'b0;
        end else begin
            bad_key_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (key_fire) begin
                        if (key_code < ALPHA) begin
                            key_q   <= key_code;
                            state_q <= S_STEP;
                        end else begin
                            bad_key_q <= 1'b1;
                        end
                    end
                end
                S_STEP: state_q <= S_ENCRYPT;
                S_ENCRYPT: begin
                    out_code_q  <= enc_out;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign enc_in    = key_q;
    assign out_code  = out_code_q;
    assign out_valid = out_valid_q;
    assign bad_key   = bad_key_q;
endmodule

// File: tb/tb_enigma_stepper.sv
// Directed bench for enigma_stepper with a modelled encryption path and a result scoreboard.
module tb_enigma_stepper;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_en = 1'b0;
    logic [4:0] load_r1 = '0, load_r2 = '0, load_r3 = '0;
    logic       key_valid = 1'b0;
    logic [4:0] key_code = '0;
    logic       out_ready = 1'b0;
    logic       key_ready, out_valid, bad_key;
    logic [4:0] r1, r2, r3, enc_in, enc_out, out_code;

    int errors = 0;
    int checks = 0;
    int m1 = 0, m2 = 0, m3 = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [4:0] enc_fn(input int x, input int a, input int b, input int c);
        return 5'((x + a + 3 * b + 7 * c + 5) % 26);
    endfunction

    // Stand-in for the external scrambler: depends on letter and all positions.
    assign enc_out = enc_fn(int'(enc_in), int'(r1), int'(r2), int'(r3));

    enigma_stepper dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en),
        .load_r1(load_r1), .load_r2(load_r2), .load_r3(load_r3),
        .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
        .r1(r1), .r2(r2), .r3(r3), .enc_in(enc_in), .enc_out(enc_out),
        .out_valid(out_valid), .out_code(out_code), .out_ready(out_ready),
        .bad_key(bad_key)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pos(input string tag, input int e1, input int e2, input int e3);
        chk({tag, " r1"}, 32'(r1), 32'(e1));
        chk({tag, " r2"}, 32'(r2), 32'(e2));
        chk({tag, " r3"}, 32'(r3), 32'(e3));
    endtask

    task automatic model_step();
        bit s2, s3;
        s2 = (m1 == 16) || (m2 == 4);
        s3 = (m2 == 4);
        m1 = (m1 + 1) % 26;
        if (s2) m2 = (m2 + 1) % 26;
        if (s3) m3 = (m3 + 1) % 26;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!key_ready && n < 20) begin tick(); n++; end
        chk("wait key_ready", 32'(key_ready), 32'd1);
    endtask

    task automatic do_load(input int a, input int b, input int c);
        wait_ready();
        load_en = 1'b1;
        load_r1 = 5'(a); load_r2 = 5'(b); load_r3 = 5'(c);
        #1;
        chk("key_ready low under load_en", 32'(key_ready), 32'd0);
        tick();
        load_en = 1'b0;
        m1 = (a < 26) ? a : 0;
        m2 = (b < 26) ? b : 0;
        m3 = (c < 26) ? c : 0;
        chk_pos("load", m1, m2, m3);
    endtask

    task automatic send_key(input int code, input int hold);
        int lat;
        logic [4:0] held;
        wait_ready();
        key_valid = 1'b1;
        key_code  = 5'(code);
        tick();
        key_valid = 1'b0;
        model_step();
        exp_q.push_back(int'(enc_fn(code, m1, m2, m3)));
        lat = 1;
        while (!out_valid && lat < 8) begin tick(); lat++; end
        chk("latency to out_valid", 32'(lat), 32'd3);
        chk_pos("model step", m1, m2, m3);
        chk("enc_in", 32'(enc_in), 32'(code));
        if (exp_q.size() == 0) begin
            chk("scoreboard empty", 32'd0, 32'd1);
        end else begin
            chk("out_code", 32'(out_code), 32'(exp_q.pop_front()));
        end
        held = out_code;
        if (hold > 0) begin
            load_en = 1'b1;
            load_r1 = 5'd3; load_r2 = 5'd3; load_r3 = 5'd3;
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("held out_valid", 32'(out_valid), 32'd1);
            chk("held out_code", 32'(out_code), 32'(held));
        end
        load_en = 1'b0;
        if (hold > 0) chk_pos("load outside idle", m1, m2, m3);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid after accept", 32'(out_valid), 32'd0);
        chk("key_ready at cycle 4", 32'(key_ready), 32'd1);
    endtask

    initial begin
        // reset state
        tick(); tick();
        chk("reset key_ready", 32'(key_ready), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset bad_key", 32'(bad_key), 32'd0);
        chk("reset out_code", 32'(out_code), 32'd0);
        chk("reset enc_in", 32'(enc_in), 32'd0);
        chk_pos("reset", 0, 0, 0);
        rst_n = 1'b1;
        #1;
        chk("key_ready after reset", 32'(key_ready), 32'd1);

        do_load(0, 0, 0);
        send_key(0, 0);
        chk_pos("key0", 1, 0, 0);

        do_load(16, 0, 0);
        send_key(5, 0);
        chk_pos("notch1", 17, 1, 0);

        do_load(15, 3, 0);
        send_key(1, 0);
        chk_pos("dbl a", 16, 3, 0);
        send_key(2, 0);
        chk_pos("dbl b", 17, 4, 0);
        send_key(3, 0);
        chk_pos("dbl c", 18, 5, 1);

        do_load(25, 25, 25);
        send_key(25, 0);
        chk_pos("wrap", 0, 25, 25);

        do_load(30, 2, 2);
        chk_pos("clamp load", 0, 2, 2);

        // bad key
        wait_ready();
        key_valid = 1'b1;
        key_code  = 5'd27;
        tick();
        key_valid = 1'b0;
        chk("bad_key pulse", 32'(bad_key), 32'd1);
        chk_pos("bad key", 0, 2, 2);
        tick();
        chk("bad_key one cycle", 32'(bad_key), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bad key no out_valid", 32'(out_valid), 32'd0);
        end
        chk_pos("bad key after", 0, 2, 2);

        // backpressure, with load_en ignored outside IDLE
        send_key(7, 5);
        chk_pos("backpressure", 1, 2, 2);

        // simultaneous load and key: load wins, key dropped
        load_en = 1'b1; key_valid = 1'b1; key_code = 5'd9;
        load_r1 = 5'd2; load_r2 = 5'd3; load_r3 = 5'd4;
        #1;
        chk("load+key key_ready", 32'(key_ready), 32'd0);
        tick();
        load_en = 1'b0; key_valid = 1'b0;
        m1 = 2; m2 = 3; m3 = 4;
        chk_pos("load+key", 2, 3, 4);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("load+key no out_valid", 32'(out_valid), 32'd0);
        end
        chk_pos("load+key no step", 2, 3, 4);

        // reset while in STEP aborts the key
        wait_ready();
        key_valid = 1'b1;
        key_code  = 5'd4;
        tick();
        key_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("key_ready in reset", 32'(key_ready), 32'd0);
        chk_pos("reset in step", 0, 0, 0);
        rst_n = 1'b1;
        #1;
        chk("key_ready after abort", 32'(key_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort no out_valid", 32'(out_valid), 32'd0);
        end
        chk_pos("abort positions", 0, 0, 0);
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
